poly_host_driver: RTL and testbench
===================================

// Module: poly_host_driver
// PURPOSE
// Host-side sequencer for the Go/DataIn quadratic evaluator (Ax^2+Bx+C).
// - Accepts one request carrying A, B, C and X in parallel on a valid/ready handshake.
// - Serialises the operands onto DataIn using the evaluator's Go press/release protocol.
// - Waits for ResultValid, captures DataResult and returns it on a valid/ready response port.
// - Sits between a test/host controller and the evaluator's Go, DataIn, DataResult and ResultValid pins.
// PARAMETERS
// DATA_W          8   operand/result width; must equal the evaluator width
// GO_HIGH_CYCLES  2   cycles Go is held high per operand (>=1)
// GO_LOW_CYCLES   1   cycles Go is held low after each operand (>=1)
// TIMEOUT         32  max cycles in WAIT_RES before reporting an error (>=8)
// PORTS
// Clock       in   1         rising-edge clock
// Resetn      in   1         asynchronous active-low reset
// req_valid   in   1         request present
// req_ready   out  1         driver can accept a request
// req_a       in   DATA_W    coefficient A
// req_b       in   DATA_W    coefficient B
// req_c       in   DATA_W    coefficient C
// req_x       in   DATA_W    variable X
// Go          out  1         to evaluator Go
// DataIn      out  DATA_W    to evaluator DataIn
// DataResult  in   DATA_W    from evaluator
// ResultValid in   1         from evaluator
// resp_valid  out  1         response present
// resp_ready  in   1         consumer accepts response
// resp_data   out  DATA_W    captured result (0 on error)
// resp_err    out  1         1 = timeout, no result seen
// BEHAVIOUR
// - Reset (Resetn=0, async): state IDLE, Go=0, DataIn=0, req_ready=1, resp_valid=0, resp_data=0, resp_err=0.
// - Reset asserted mid-operation drops Go immediately. The operation is lost and no response is issued.
// - All outputs are registered.
// - FSM states: IDLE, DRIVE_HI, DRIVE_LO, WAIT_RES, RESP.
// - IDLE: req_ready=1. On req_valid at an edge, latch A/B/C/X, set idx=0, and go to DRIVE_HI.
//   Inputs are never sampled outside IDLE.
// - DRIVE_HI: DataIn = operand[idx] in order A, B, C, X; Go=1 for exactly GO_HIGH_CYCLES cycles.
// - DRIVE_LO: Go=0 for exactly GO_LOW_CYCLES cycles, with DataIn held at the same operand.
//   If idx<3, increment idx and return to DRIVE_HI; otherwise go to WAIT_RES.
// - DataIn changes only on entry to DRIVE_HI. It is stable for the whole high phase and low phase.
// - WAIT_RES: Go=0 and a cycle counter starts at 0.
//   - ResultValid sampled 1: capture DataResult into resp_data, resp_err=0, go to RESP.
//   - Counter reaches TIMEOUT: resp_data=0, resp_err=1, go to RESP.
//   - ResultValid seen on the same edge the counter hits TIMEOUT: the result wins.
// - ResultValid is ignored in every state except WAIT_RES.
//   This prevents a stale ResultValid (held in the evaluator's idle load state) from being captured.
// - RESP: resp_valid=1, with resp_data and resp_err stable until resp_ready.
//   On resp_valid&resp_ready, return to IDLE; req_ready=1 the next cycle, with no bubble beyond that.
// - Arithmetic is performed in the evaluator. The driver passes DATA_W bits through without modification.
// - Latency with default parameters: resp_valid first high 19 cycles after the accept edge.
//   - Drive phase: 12 cycles.
//   - Evaluator: 5 compute cycles, plus 1 transition cycle, plus 1 sample cycle.
// TESTING
// 1. Reset with the evaluator attached; A=1,B=2,C=3,X=4 -> resp_data=27, resp_err=0, resp_valid at accept+19.
// 2. Overflow: A=5,B=0,C=0,X=8 -> resp_data=64 (320 mod 256); then A=0,B=0,C=7,X=9 back-to-back -> 7.
// 3. Protocol check: Go high exactly 2 cycles and low 1 cycle per operand, 4 pulses, DataIn = A,B,C,X stable while Go=1.
// 4. Evaluator stub that never raises ResultValid -> resp_err=1, resp_data=0 after TIMEOUT=32 cycles in WAIT_RES.
// 5. resp_ready held 0 for 10 cycles -> resp_valid/resp_data held and req_ready=0 until accept; new req ignored meanwhile.
// 6. Resetn pulsed low during the third operand -> Go=0 asynchronously, no response; next request (1,1,1,1) -> 3.

Source files
------------

// File: rtl/poly_host_driver.sv
// Host-side sequencer for a Go/DataIn quadratic evaluator: takes A/B/C/X on a
// request handshake, pulses them out on Go/DataIn, and returns the result or a timeout.
module poly_host_driver #(
  parameter int DATA_W         = 8,
  parameter int GO_HIGH_CYCLES = 2,
  parameter int GO_LOW_CYCLES  = 1,
  parameter int TIMEOUT        = 32
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [DATA_W-1:0] req_c,
  input  logic [DATA_W-1:0] req_x,
  output logic              Go,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataResult,
  input  logic              ResultValid,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  localparam int PH_MAX = (GO_HIGH_CYCLES > GO_LOW_CYCLES) ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE_HI,
    S_DRIVE_LO,
    S_WAIT_RES,
    S_RESP
  } state_e;

  state_e                       state_q, state_d;
  logic [3:0][DATA_W-1:0]       opnd_q, opnd_d;
  logic [1:0]                   idx_q, idx_d;
  logic [PH_W-1:0]              ph_cnt_q, ph_cnt_d;
  logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
  logic                         go_q, go_d;
  logic [DATA_W-1:0]            data_in_q, data_in_d;
  logic                         req_ready_q, req_ready_d;
  logic                         resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]            resp_data_q, resp_data_d;
  logic                         resp_err_q, resp_err_d;

  // NOTE: every _d gets its current _q first, so no path through the case
  // statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    opnd_d       = opnd_q;
    idx_d        = idx_q;
    ph_cnt_d     = ph_cnt_q;
    to_cnt_d     = to_cnt_q;
    go_d         = go_q;
    data_in_d    = data_in_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          opnd_d      = {req_x, req_c, req_b, req_a};
          idx_d       = 2'd0;
          ph_cnt_d    = '0;
          go_d        = 1'b1;
          data_in_d   = req_a;
          req_ready_d = 1'b0;
          state_d     = S_DRIVE_HI;
        end
      end

      S_DRIVE_HI: begin
        if (ph_cnt_q == PH_W'(GO_HIGH_CYCLES - 1)) begin
          ph_cnt_d = '0;
          go_d     = 1'b0;
          state_d  = S_DRIVE_LO;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end

      S_DRIVE_LO: begin
        if (ph_cnt_q == PH_W'(GO_LOW_CYCLES - 1)) begin
          ph_cnt_d = '0;
          if (idx_q != 2'd3) begin
            // DataIn only moves here, at the start of the next high phase.
            idx_d     = idx_q + 2'd1;
            data_in_d = opnd_q[idx_q + 2'd1];
            go_d      = 1'b1;
            state_d   = S_DRIVE_HI;
          end else begin
            to_cnt_d = '0;
            state_d  = S_WAIT_RES;
          end
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end

      S_WAIT_RES: begin
        // A result arriving on the timeout edge takes priority over the error.
        if (ResultValid) begin
          resp_data_d  = DataResult;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: begin
        go_d         = 1'b0;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  // NOTE: the operand registers are only a 4-entry bank, so they are reset along
  // with the control state rather than left to power up unknown.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      opnd_q       <= '0;
      idx_q        <= 2'd0;
      ph_cnt_q     <= '0;
      to_cnt_q     <= '0;
      go_q         <= 1'b0;
      data_in_q    <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      opnd_q       <= opnd_d;
      idx_q        <= idx_d;
      ph_cnt_q     <= ph_cnt_d;
      to_cnt_q     <= to_cnt_d;
      go_q         <= go_d;
      data_in_q    <= data_in_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign Go         = go_q;
  assign DataIn     = data_in_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_poly_host_driver.sv
// Bench for poly_host_driver: a behavioural Go/DataIn evaluator plus a
// scoreboard queue that a free-running monitor drains on every response.
module tb_poly_host_driver;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a, req_b, req_c, req_x;
  logic         Go;
  logic [W-1:0] DataIn;
  logic [W-1:0] DataResult;
  logic         ResultValid;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic         resp_err;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb_q[$];
  bit   in_resp = 1'b0;

  poly_host_driver #(
    .DATA_W(W), .GO_HIGH_CYCLES(2), .GO_LOW_CYCLES(1), .TIMEOUT(32)
  ) dut (
    .Clock(Clock), .Resetn(Resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_x(req_x),
    .Go(Go), .DataIn(DataIn), .DataResult(DataResult), .ResultValid(ResultValid),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Evaluator model: latches an operand on each Go release, raises ResultValid
  // 6 edges after the fourth release and holds it until the next Go press.
  logic         ev_prev_go;
  logic [1:0]   ev_idx;
  logic [W-1:0] ev_ops [4];
  logic [W-1:0] ev_res;
  int           ev_cnt;
  bit           ev_dead = 1'b0;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ev_prev_go  <= 1'b0;
      ev_idx      <= 2'd0;
      ev_cnt      <= 0;
      ev_res      <= '0;
      ResultValid <= 1'b0;
      DataResult  <= '0;
    end else begin
      ev_prev_go <= Go;
      if (Go && !ev_prev_go) ResultValid <= 1'b0;
      if (!Go && ev_prev_go) begin
        if (ev_idx == 2'd3) begin
          ev_res <= ev_ops[0] * DataIn * DataIn + ev_ops[1] * DataIn + ev_ops[2];
          if (!ev_dead) ev_cnt <= 6;
          ev_idx <= 2'd0;
        end else begin
          ev_ops[ev_idx] <= DataIn;
          ev_idx <= ev_idx + 2'd1;
        end
      end
      if (ev_cnt != 0) begin
        ev_cnt <= ev_cnt - 1;
        if (ev_cnt == 1) begin
          ResultValid <= 1'b1;
          DataResult  <= ev_res;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle a response is presented, pops on handshake.
  initial begin
    forever begin
      @(negedge Clock);
      #1;
      if (Resetn && resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          if (!in_resp) begin
            in_resp = 1'b1;
            check("latency", cyc - sb_q[0].acc, sb_q[0].lat);
          end
          check("resp_data", resp_data, sb_q[0].data);
          check("resp_err", resp_err, sb_q[0].err);
          if (resp_ready) begin
            void'(sb_q.pop_front());
            in_resp = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, b, c, x, input logic [W-1:0] ed,
                      input logic ee, input int el, input bit push);
    int budget;
    int acc;
    @(negedge Clock);
    req_a = a; req_b = b; req_c = c; req_x = x;
    req_valid = 1'b1;
    budget = 0;
    while (!req_ready && budget < 100) begin
      @(negedge Clock);
      budget++;
    end
    if (!req_ready) begin
      check("accept_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (push) sb_q.push_back('{data: ed, err: ee, lat: el, acc: acc});
    @(posedge Clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic check_protocol(input logic [W-1:0] a, b, c, x);
    logic [W-1:0] ops [4];
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = x;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clock);
      check("go_pattern", 32'(Go), 32'((i % 3) != 2));
      check("datain_stable", DataIn, ops[i / 3]);
    end
    @(negedge Clock);
    check("go_low_wait", 32'(Go), 32'd0);
  endtask

  task automatic drain(input int limit);
    int budget = 0;
    while (sb_q.size() != 0 && budget < limit) begin
      @(negedge Clock);
      budget++;
    end
    check("sb_drain", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_c = '0; req_x = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge Clock);
    check("rst_go", 32'(Go), 32'd0);
    check("rst_datain", DataIn, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    Resetn = 1'b1;

    // Basic evaluation plus Go/DataIn waveform: 16+8+3 = 27
    send(8'd1, 8'd2, 8'd3, 8'd4, 8'd27, 1'b0, 19, 1'b1);
    check_protocol(8'd1, 8'd2, 8'd3, 8'd4);

    // Overflow (320 mod 256 = 64), then back-to-back C-only request, then all-ones (-1+1-1 = 255)
    send(8'd5, 8'd0, 8'd0, 8'd8, 8'd64, 1'b0, 19, 1'b1);
    send(8'd0, 8'd0, 8'd7, 8'd9, 8'd7, 1'b0, 19, 1'b1);
    send(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 19, 1'b1);
    drain(100);

    // Dead evaluator: 12 drive cycles + 32 in WAIT_RES
    ev_dead = 1'b1;
    send(8'd9, 8'd9, 8'd9, 8'd9, 8'd0, 1'b1, 44, 1'b1);
    drain(100);
    ev_dead = 1'b0;

    // Back-pressure: 50+15+4 = 69 held while a competing request is ignored
    resp_ready = 1'b0;
    send(8'd2, 8'd3, 8'd4, 8'd5, 8'd69, 1'b0, 19, 1'b1);
    budget = 0;
    while (!resp_valid && budget < 40) begin
      @(negedge Clock);
      budget++;
    end
    check("resp_seen", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_go_idle", 32'(Go), 32'd0);
      req_a = 8'd11; req_b = 8'd12; req_c = 8'd13; req_x = 8'd14;
      req_valid = 1'b1;
      @(negedge Clock);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge Clock);
    check("bp_req_ready_after", 32'(req_ready), 32'd1);
    check("bp_no_go", 32'(Go), 32'd0);
    drain(10);

    // Reset during the third operand's high phase
    send(8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 1'b0, 0, 1'b0);
    repeat (7) @(negedge Clock);
    check("pre_reset_go", 32'(Go), 32'd1);
    check("pre_reset_datain", DataIn, 32'd8);
    @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    check("async_go_drop", 32'(Go), 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd1);
    check("async_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    send(8'd1, 8'd1, 8'd1, 8'd1, 8'd3, 1'b0, 19, 1'b1);
    drain(100);

    repeat (5) @(negedge Clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
